// File: rtl/dsp_nco_rom_arb.sv
// dsp_nco_rom_arb: shares one NCO sin/cos ROM read port between NUM_REQ
// requesters. One lookup per clock via req/gnt. The granted address drives
// the ROM. A ROM_LAT-deep tag pipeline routes each returning ROM word back to
// the requester that issued it.
// Optional macro DSP_NCO_ROM_ARB_FIXED_PRIO_EN: when defined, fixed priority
// (lowest index wins, no rotating pointer); when undefined, round-robin.
module dsp_nco_rom_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int ROM_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_dout,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]                rr_ptr_q;
    logic [ADDR_WIDTH-1:0]           last_addr_q, last_addr_d;
    logic [ROM_LAT-1:0]              vld_q, vld_d;
    logic [ROM_LAT-1:0][NUM_REQ-1:0] id_q, id_d;
    logic                            granted;
    logic [ADDR_WIDTH-1:0]           sel_addr;
    logic [PTR_W:0]                  sum;
    logic [PTR_W-1:0]                idx;

`ifdef DSP_NCO_ROM_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at index 0.
    assign rr_ptr_q = '0;
`else
    logic [PTR_W-1:0] rr_ptr_d;

    // Round-robin pointer register: index that has top priority next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Search from rr_ptr upward with wrap; first asserted request wins and
    // its address is muxed onto the ROM port in the same cycle.
    always_comb begin
        gnt      = '0;
        granted  = 1'b0;
        sel_addr = last_addr_q;
        sum      = '0;
        idx      = '0;
`ifdef DSP_NCO_ROM_ARB_FIXED_PRIO_EN
`else
        rr_ptr_d = rr_ptr_q;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[PTR_W-1:0];
            if (!rst && !granted && req[idx]) begin
                granted  = 1'b1;
                gnt[idx] = 1'b1;
                sel_addr = req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef DSP_NCO_ROM_ARB_FIXED_PRIO_EN
`else
                rr_ptr_d = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
`endif
            end
        end
    end

    assign rom_addr = sel_addr;

    // Next state for the held address and the in-flight tag pipeline.
    always_comb begin
        last_addr_d = granted ? sel_addr : last_addr_q;
        vld_d       = '0;
        id_d        = '0;
        vld_d[0]    = granted;
        id_d[0]     = gnt;
        for (int j = 1; j < ROM_LAT; j++) begin
            vld_d[j] = vld_q[j-1];
            id_d[j]  = id_q[j-1];
        end
    end

    // Registers for the held address and the tag pipeline; reset discards
    // every lookup still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr_q <= '0;
            vld_q       <= '0;
            id_q        <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            vld_q       <= vld_d;
            id_q        <= id_d;
        end
    end

    // Responses are suppressed while reset is held so no stale strobe escapes.
    assign rsp_valid = (vld_q[ROM_LAT-1] && !rst) ? id_q[ROM_LAT-1] : '0;
    assign rsp_data  = rom_dout;
    assign busy      = (|vld_q) && !rst;

endmodule

// File: tb/tb_dsp_nco_rom_arb.sv
// Testbench for dsp_nco_rom_arb with a behavioural ROM and reference model.
module tb_dsp_nco_rom_arb;

    localparam int N   = 3;
    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_dout;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    dsp_nco_rom_arb #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural sin ROM with LAT registered stages on the read path.
    logic [DW-1:0] rom_mem [1 << AW];
    logic [DW-1:0] rom_s1, rom_s2;
    always @(posedge clk) begin
        rom_s1 <= rom_mem[rom_addr];
        rom_s2 <= rom_s1;
    end
    assign rom_dout = (LAT == 1) ? rom_s1 : rom_s2;

    // Scoreboard of issued lookups.
    typedef struct {
        int due;
        int id;
        int addr;
    } item_t;
    item_t pend[$];

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;
    int ptr_m       = 0;
    int last_addr_m = 0;
    int last_g      = -1;
    bit prev_rst    = 1'b0;
    bit sweep_started = 1'b0;
    logic [AW-1:0] sweep_addr;
    logic          stim_req  [N];
    logic [AW-1:0] stim_addr [N];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Modes: 0 reset, 1 sweep req0, 2 all held, 3 random, 4 only N-2, 5 only 0, 6 idle
    task automatic applyStimulus(input int mode);
        rst = (mode == 0);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0: begin stim_req[k] = 1'b1; stim_addr[k] = AW'($urandom); end
                1: begin
                    stim_req[k] = (k == 0);
                    if (k == 0) begin
                        if (sweep_started && last_g == 0) sweep_addr = sweep_addr + 1'b1;
                        sweep_started = 1'b1;
                        stim_addr[k] = sweep_addr;
                    end
                end
                2: begin
                    stim_req[k]  = 1'b1;
                    stim_addr[k] = (k == 0) ? AW'(5) : (k == 1) ? AW'(256) : AW'(512);
                end
                3: begin
                    if (stim_req[k] && last_g != k && !prev_rst) begin
                        if ($urandom_range(0, 9) == 0) stim_req[k] = 1'b0;
                    end else begin
                        stim_req[k]  = ($urandom_range(0, 2) != 0);
                        stim_addr[k] = AW'($urandom);
                    end
                end
                4: stim_req[k] = (k == N - 2);
                5: stim_req[k] = (k == 0);
                default: stim_req[k] = 1'b0;
            endcase
            req[k] = stim_req[k];
            req_addr[k*AW +: AW] = stim_addr[k];
        end
        if (mode == 3) rst = ($urandom_range(0, 99) == 0);
    endtask

    // Reference: grant by round-robin (or fixed) search, responses LAT clocks later.
    task automatic checkCycle();
        int g;
        int idx;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rv;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        bit settled;
        g = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                idx = (ptr_m + i) % N;
                if (g < 0 && stim_req[idx]) g = idx;
            end
        end
        exp_gnt = '0;
        if (g >= 0) exp_gnt[g] = 1'b1;
        exp_addr = (g >= 0) ? stim_addr[g] : AW'(last_addr_m);
        exp_rv   = '0;
        exp_data = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rv[pend[0].id] = 1'b1;
            exp_data = rom_mem[pend[0].addr];
        end
        settled = !(rst && !prev_rst);
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        if (settled) begin
            checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            checkOutput("busy", 32'(busy), 32'(pend.size() > 0));
            if (exp_rv != '0) checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
        end
        if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
        if (rst) begin
            pend.delete();
            ptr_m       = 0;
            last_addr_m = 0;
        end else if (g >= 0) begin
`ifdef DSP_NCO_ROM_ARB_FIXED_PRIO_EN
            ptr_m = 0;
`else
            ptr_m = (g + 1) % N;
`endif
            last_addr_m = int'(stim_addr[g]);
            pend.push_back('{due: cyc + LAT, id: g, addr: int'(stim_addr[g])});
        end
        prev_rst = rst;
        last_g   = g;
        cyc++;
    endtask

    task automatic runCycles(input int mode, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(mode);
            @(negedge clk);
            checkCycle();
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            rom_mem[a] = DW'(int'($sin(6.283185307 * a / (1 << AW)) * 32767.0));
        end
        for (int k = 0; k < N; k++) begin
            stim_req[k]  = 1'b0;
            stim_addr[k] = '0;
        end
        rst        = 1'b1;
        req        = '0;
        req_addr   = '0;
        sweep_addr = '0;

        runCycles(0, 3);
        runCycles(1, 1 << AW);
        runCycles(6, 3);
        runCycles(2, 12);
        runCycles(4, 1);
        runCycles(5, 2);
        runCycles(2, 1);
        runCycles(0, 1);
        runCycles(2, 4);
        runCycles(3, 3000);
        runCycles(6, LAT + 2);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/dsp_nco_rom_arb.md
Name: dsp_nco_rom_arb

Overview:
- Round-robin arbiter that shares one dsp_nco_rom read port (sin or cos table) between NUM_REQ requesters, such as several NCO phase accumulators or mixer channels.
- Accepts one lookup per cycle using a req/gnt handshake and drives the ROM address.
- Tracks in-flight lookups through a latency pipeline that matches the ROM's read latency.
- Returns each ROM word to the requester that issued it, with a one-hot response strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 10, ROM address width; must equal the ROM's ADDR_WIDTH.
- DATA_WIDTH, 16, ROM data width; must equal the ROM's DATA_WIDTH.
- ROM_LAT, 1, ROM read latency in clocks: 1 when ROM REG_OUT=0, 2 when REG_OUT=1. Legal range 1..4.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous reset, active-high.
- req, input, NUM_REQ: per-requester lookup request.
- req_addr, input, NUM_REQ*ADDR_WIDTH: packed request addresses. Requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- gnt, output, NUM_REQ: one-hot grant, combinational in the same cycle as req.
- rom_addr, output, ADDR_WIDTH: address to the shared ROM.
- rom_dout, input, DATA_WIDTH: ROM read data.
- rsp_valid, output, NUM_REQ: one-hot response strobe.
- rsp_data, output, DATA_WIDTH: response word, shared by all requesters and qualified by rsp_valid.
- busy, output, 1: high while any lookup is in flight in the pipeline.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Handshake:
  - A request transfers in any cycle where req[k]=1 and gnt[k]=1.
  - A requester holds req[k] and its address stable until it sees gnt[k]. Dropping req[k] before grant is legal; no transfer occurs.
  - At most one gnt bit is high per cycle.
  - gnt is 0 whenever req is 0 or rst=1.
- Arbitration (round-robin):
  - Register rr_ptr (log2 NUM_REQ bits) holds the highest-priority index.
  - The search starts at rr_ptr and wraps modulo NUM_REQ. The first asserted req is granted.
  - After a grant to index k, rr_ptr <= (k+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - A lone requester holding req gets a grant every cycle (throughput 1 lookup/clk).
- ROM address:
  - In a grant cycle, rom_addr = req_addr of the granted requester (combinational mux).
  - Otherwise rom_addr = last_addr, a register updated on every grant.
  - Reset value of last_addr is 0.
- Latency pipeline:
  - Shift register of depth ROM_LAT. Each stage holds {vld, one-hot id}.
  - Stage 0 loads {|gnt, gnt} at each clk edge.
- Response:
  - rsp_valid = stage[ROM_LAT-1].id when stage[ROM_LAT-1].vld=1, else 0.
  - rsp_data = rom_dout (combinational pass-through).
  - Net effect: rsp_valid[k] rises exactly ROM_LAT clocks after the cycle in which gnt[k] was high. rsp_data then equals ROM[addr issued].
  - Responses return in issue order; there is no backpressure on responses.
- busy:
  - OR of all pipeline vld bits.
- Reset values:
  - gnt=0, rsp_valid=0, busy=0, rom_addr=0, rr_ptr=0, all pipeline stages cleared.
- Boundary conditions:
  - All requesters active: grants rotate 0,1,...,NUM_REQ-1,0,... with no starvation. Maximum wait is NUM_REQ-1 cycles.
  - Grant to k while a response for k is returning in the same cycle: both proceed independently.
  - rr_ptr at NUM_REQ-1 with req[0] only: grant 0, then rr_ptr wraps to 1.
  - rst asserted mid-operation: in-flight lookups are discarded and no rsp_valid pulses appear after reset. The first grant after reset follows the reset priority (index 0 first).
  - Address wrap is the requester's responsibility; the arbiter passes addresses unmodified.

Optional Feature:
- Macro: DSP_NCO_ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed (tied to 0) and starvation of high indices is allowed.
- Undefined (default): round-robin as described above.
- All other timing is identical in both modes.

Test Plan (NUM_REQ=2, ADDR_WIDTH=10, DATA_WIDTH=16, ROM sin table, ROM_LAT=1 unless stated):
1. Reset: hold rst=1 for 3 clks with req=2'b11 -> gnt=0, rsp_valid=0, busy=0, rom_addr=0 throughout.
2. Single requester sweep: req[0] held, addr 0..1023 incrementing on each grant -> gnt[0] every cycle. rsp_valid[0] one clk later and rsp_data equals golden sin table entry for each address; 1024 responses, 0 mismatches.
3. Contention: req=2'b11 with addr0=5 and addr1=256 held -> gnt alternates 01,10,01,... starting with 01. rsp_valid alternates one clk later, with rsp_data = sin[5] / sin[256] matching the id.
4. ROM_LAT=2 (ROM REG_OUT=1): grant to requester 1 at cycle t with addr=512 -> rsp_valid=2'b10 exactly at cycle t+2 with rsp_data=sin[512]. busy is high during t+1..t+2.
5. Reset mid-flight: grant at cycle t, rst=1 at cycle t+1 edge, ROM_LAT=2 -> no rsp_valid pulse at t+2. After rst deasserts, the first grant with req=2'b11 goes to index 0.
6. With DSP_NCO_ROM_ARB_FIXED_PRIO_EN defined and req=2'b11 held for 10 clks -> gnt=01 every cycle and gnt[1] never asserts; then drop req[0] -> gnt=10 in the same cycle.
